// File: rtl/knn_pkg.sv
// Shared constants, FSM state codes and the k-normalisation helper for the
// K-nearest-neighbour vote block.
package knn_pkg;

    localparam int W           = 16;
    localparam int TYPE_W      = 3;
    localparam int NUM_CLASSES = 1 << TYPE_W;
    localparam int K_MAX       = 15;
    localparam int K_W         = 4;

    // FSM state codes
    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_SCAN    = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    // k of zero still votes one neighbour; anything above K_MAX is clipped.
    function automatic logic [K_W-1:0] k_effective(input logic [K_W-1:0] k_in);
        logic [K_W-1:0] k_out;
        if (k_in == {K_W{1'b0}}) begin
            k_out = K_W'(1);
        end else if (k_in > K_W'(K_MAX)) begin
            k_out = K_W'(K_MAX);
        end else begin
            k_out = k_in;
        end
        return k_out;
    endfunction

endpackage

// File: rtl/knn_argmax_step.sv
// One step of the class argmax: decides whether the candidate class replaces
// the current best. Higher vote count wins; on equal count the class whose
// first vote came at the lower rank (the closer neighbour) wins. Classes with
// no votes never win.
module knn_argmax_step
    import knn_pkg::*;
(
    input  logic [K_W:0]   cand_cnt,
    input  logic [K_W-1:0] cand_first,
    input  logic [K_W:0]   best_cnt,
    input  logic [K_W-1:0] best_first,
    output logic           take
);

    // Candidate-vs-best comparison with nearest-member tie break
    always_comb begin
        take = 1'b0;
        if (cand_cnt == {(K_W+1){1'b0}}) begin
            take = 1'b0;
        end else if (cand_cnt > best_cnt) begin
            take = 1'b1;
        end else if ((cand_cnt == best_cnt) && (cand_first < best_first)) begin
            take = 1'b1;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/knn_vote.sv
// K-nearest-neighbour vote: consumes an ascending-distance stream of
// (distance, class) beats, votes over the first k_eff beats, then scans the
// per-class counters one class per cycle and presents a held result.
module knn_vote
    import knn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [K_W-1:0]    k,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_dist,
    input  logic [TYPE_W-1:0] in_type,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TYPE_W-1:0] out_class,
    output logic [K_W:0]      out_votes,
    output logic [W-1:0]      out_nearest,
    output logic [K_W:0]      out_n
);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [K_W-1:0]    rank;
    logic [K_W-1:0]    k_eff;
    logic [K_W:0]      cnt   [NUM_CLASSES];
    logic [K_W-1:0]    first [NUM_CLASSES];
    logic [TYPE_W-1:0] idx;
    logic [K_W:0]      best_cnt;
    logic [K_W-1:0]    best_first;
    logic [TYPE_W-1:0] best_class;

    logic              accept;
    logic              vote;
    logic              out_done;
    logic              scan_last;
    logic              enter_scan;
    logic              take;
    logic [K_W-1:0]    cur_keff;
    logic [K_W-1:0]    rank_inc;

    assign accept     = in_valid & in_ready;
    assign out_done   = out_valid & out_ready;
    assign scan_last  = (state == ST_SCAN) && (idx == TYPE_W'(NUM_CLASSES - 1));
    assign enter_scan = (next_state == ST_SCAN) && (state != ST_SCAN);

    // k is only honoured on the rank-0 beat; later beats use the latched copy
    always_comb begin
        cur_keff = k_eff;
        rank_inc = rank;
        vote     = 1'b0;
        if (rank == {K_W{1'b0}}) begin
            cur_keff = k_effective(k);
        end else begin
            cur_keff = k_eff;
        end
        if (rank == K_W'(K_MAX)) begin
            rank_inc = rank;
        end else begin
            rank_inc = rank + K_W'(1);
        end
        if (accept && (state == ST_COLLECT) && (rank < cur_keff)) begin
            vote = 1'b1;
        end else begin
            vote = 1'b0;
        end
    end

    // Next-state decision for the collect / drain / scan / hold sequence
    always_comb begin
        next_state = state;
        case (state)
            ST_COLLECT: begin
                if (accept && in_last) begin
                    next_state = ST_SCAN;
                end else if (vote && (rank_inc == cur_keff)) begin
                    next_state = ST_DRAIN;
                end else begin
                    next_state = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (accept && in_last) begin
                    next_state = ST_SCAN;
                end else begin
                    next_state = ST_DRAIN;
                end
            end
            ST_SCAN: begin
                if (scan_last) begin
                    next_state = ST_HOLD;
                end else begin
                    next_state = ST_SCAN;
                end
            end
            ST_HOLD: begin
                if (out_done) begin
                    next_state = ST_COLLECT;
                end else begin
                    next_state = ST_HOLD;
                end
            end
            default: next_state = ST_COLLECT;
        endcase
    end

    // State register and registered in_ready (low during reset, high once running)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_COLLECT;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == ST_COLLECT) || (next_state == ST_DRAIN);
        end
    end

    // Per-class vote counters and the rank of each class's first vote
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                cnt[c]   <= {(K_W+1){1'b0}};
                first[c] <= {K_W{1'b0}};
            end
        end else if ((state == ST_HOLD) && out_done) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                cnt[c]   <= {(K_W+1){1'b0}};
                first[c] <= {K_W{1'b0}};
            end
        end else if (vote) begin
            cnt[in_type] <= cnt[in_type] + (K_W+1)'(1);
            if (cnt[in_type] == {(K_W+1){1'b0}}) begin
                first[in_type] <= rank;
            end else begin
                first[in_type] <= first[in_type];
            end
        end else begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                cnt[c]   <= cnt[c];
                first[c] <= first[c];
            end
        end
    end

    // Rank counter, latched k_eff and nearest distance of the current stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rank        <= {K_W{1'b0}};
            k_eff       <= K_W'(1);
            out_nearest <= {W{1'b0}};
        end else if ((state == ST_HOLD) && out_done) begin
            rank        <= {K_W{1'b0}};
            k_eff       <= k_eff;
            out_nearest <= out_nearest;
        end else if (vote) begin
            rank <= rank_inc;
            if (rank == {K_W{1'b0}}) begin
                k_eff       <= cur_keff;
                out_nearest <= in_dist;
            end else begin
                k_eff       <= k_eff;
                out_nearest <= out_nearest;
            end
        end else begin
            rank        <= rank;
            k_eff       <= k_eff;
            out_nearest <= out_nearest;
        end
    end

    knn_argmax_step u_argmax (
        .cand_cnt   (cnt[idx]),
        .cand_first (first[idx]),
        .best_cnt   (best_cnt),
        .best_first (best_first),
        .take       (take)
    );

    // Sequential argmax scan, one class per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= {TYPE_W{1'b0}};
            best_cnt   <= {(K_W+1){1'b0}};
            best_first <= {K_W{1'b1}};
            best_class <= {TYPE_W{1'b0}};
        end else if (enter_scan) begin
            idx        <= {TYPE_W{1'b0}};
            best_cnt   <= {(K_W+1){1'b0}};
            best_first <= {K_W{1'b1}};
            best_class <= {TYPE_W{1'b0}};
        end else if (state == ST_SCAN) begin
            idx <= idx + TYPE_W'(1);
            if (take) begin
                best_cnt   <= cnt[idx];
                best_first <= first[idx];
                best_class <= idx;
            end else begin
                best_cnt   <= best_cnt;
                best_first <= best_first;
                best_class <= best_class;
            end
        end else begin
            idx        <= idx;
            best_cnt   <= best_cnt;
            best_first <= best_first;
            best_class <= best_class;
        end
    end

    // Result registers: loaded on the final scan step, held until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_class <= {TYPE_W{1'b0}};
            out_votes <= {(K_W+1){1'b0}};
            out_n     <= {(K_W+1){1'b0}};
        end else if (scan_last) begin
            out_valid <= 1'b1;
            out_class <= take ? idx : best_class;
            out_votes <= take ? cnt[idx] : best_cnt;
            out_n     <= {1'b0, rank};
        end else if ((state == ST_HOLD) && out_done) begin
            out_valid <= 1'b0;
            out_class <= out_class;
            out_votes <= out_votes;
            out_n     <= out_n;
        end else begin
            out_valid <= out_valid;
            out_class <= out_class;
            out_votes <= out_votes;
            out_n     <= out_n;
        end
    end

endmodule

// File: doc/knn_vote.md
Name: knn_vote

Overview:
Consumer at the output end of the distance sort network. It accepts the ascending-sorted stream of (distance, type) pairs, keeps the first K entries (the K nearest neighbours) and counts votes per class. It then emits one classification result per stream.
Sits between the final sort stage and the classifier result register/host interface.

Parameters:
W, 16, distance width (matches sort stage)
TYPE_W, 3, class label width; NUM_CLASSES = 2**TYPE_W
K_MAX, 15, largest supported K
K_W, 4, width of k port and rank counter; must hold K_MAX

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
k  in  K_W  neighbours to vote; sampled on first accepted beat of each stream
in_valid  in  1  input beat valid
in_ready  out  1  block can accept beat
in_dist  in  W  distance of beat (ascending order within stream)
in_type  in  TYPE_W  class label of beat
in_last  in  1  final beat of stream
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_class  out  TYPE_W  winning class
out_votes  out  K_W+1  vote count of winning class
out_nearest  out  W  distance of rank-0 beat
out_n  out  K_W+1  number of beats actually voted (min(k, stream length))

Behaviour:
- Reset (async, rst=1): state=COLLECT; all per-class counters, first-rank registers, rank counter and best registers cleared; in_ready=0 while rst high, then 1; out_valid=0; out_class=0; out_votes=0; out_nearest=0; out_n=0.
- Handshakes: input beat accepted when in_valid & in_ready; result consumed when out_valid & out_ready. out_* hold stable while out_valid & !out_ready.
- k_eff = (k==0) ? 1 : min(k, K_MAX); latched on rank-0 beat.
- States:
  - COLLECT (in_ready=1): per accepted beat with rank < k_eff: cnt[in_type]++; if cnt[in_type] was 0, first[in_type] <= rank; rank==0 also latches out_nearest. rank++ (saturating at K_MAX). Once rank reaches k_eff with !in_last -> DRAIN. On in_last -> SCAN.
  - DRAIN (in_ready=1): beats accepted and discarded; on in_last -> SCAN.
  - SCAN (in_ready=0): idx 0..NUM_CLASSES-1, one class per cycle. Class idx beats best if cnt>0 and (cnt>best_cnt, or cnt==best_cnt and first<best_first). Equal-count tie therefore goes to the class whose nearest member is closest. After idx NUM_CLASSES-1 -> HOLD.
  - HOLD (in_ready=0, out_valid=1): on out handshake, clear counters/rank -> COLLECT. out_valid drops the following cycle.
- Latency: last beat accepted in cycle t -> out_valid=1 in cycle t+NUM_CLASSES+1 (t+9 at defaults).
- Single-beat stream (in_last on rank 0) is legal: out_n=1, out_votes=1.
- Stream shorter than k_eff: votes over received beats only; out_n=beats received.
- in_valid while in_ready=0: beat not accepted and upstream must hold it; no internal state change.
- Input ordering is not checked; unsorted input produces a deterministic vote over the first k_eff beats.
- Counter widths K_W+1 never overflow because the rank guard bounds every count by K_MAX.
- rst mid-stream or mid-SCAN: immediate abort. Partial stream is discarded and no result is emitted. Upstream must restart the stream.

Decomposition:
- Shared package knn_pkg: W, TYPE_W, NUM_CLASSES, K_MAX, K_W constants; state enum {COLLECT, DRAIN, SCAN, HOLD}.
- Sub-module knn_argmax_step: combinational compare of (cnt, first) candidate against (best_cnt, best_first). Same tie rule as above. Instantiated once inside the SCAN datapath.

Test Plan:
- k=3, stream types {2,5,2,1,7} dists {1,3,4,9,12}, last on beat 5 -> beats 4-5 drained; out_class=2, out_votes=2, out_n=3, out_nearest=1, out_valid 9 cycles after last beat.
- k=4, types {6,3,3,6} -> tie 2/2; class 6 wins (first rank 0 < 1); out_votes=2.
- k=5, single beat type 4 dist 0x00FF, last -> out_class=4, out_votes=1, out_n=1, out_nearest=0x00FF.
- k=0, types {1,1,2} -> treated as k=1; out_class=1, out_votes=1, out_n=1.
- Result held with out_ready=0 for 20 cycles while in_valid=1 -> in_ready=0, outputs stable, no beat consumed. Next stream is accepted only after the out handshake.
- rst asserted asynchronously during the SCAN of stream types {3,3} -> out_valid never rises. Next stream types {5} k=1 yields out_class=5, out_votes=1.
